id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 119 +++++++++++
 1 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: one-cycle registered copy of decode outputs with stall, flush and bubble insertion.
// Optional flush counter on bubble_cnt is enabled by defining ID_EX_BUBBLE_CNT_EN; otherwise bubble_cnt is tied to 0.
module id_ex_reg #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_pc_plus4,
    input  logic [WIDTH-1:0] in_rd1,
    input  logic [WIDTH-1:0] in_rd2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [REGW-1:0]  in_rs1,
    input  logic [REGW-1:0]  in_rs2,
    input  logic [REGW-1:0]  in_rd,
    input  logic             in_reg_write,
    input  logic             in_mem_write,
    input  logic             in_mem_read,
    input  logic             in_jump,
    input  logic             in_branch,
    input  logic             in_alu_src,
    input  logic [1:0]       in_result_src,
    input  logic [2:0]       in_alu_ctrl,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc_plus4,
    output logic [WIDTH-1:0] out_rd1,
    output logic [WIDTH-1:0] out_rd2,
    output logic [WIDTH-1:0] out_imm,
    output logic [REGW-1:0]  out_rs1,
    output logic [REGW-1:0]  out_rs2,
    output logic [REGW-1:0]  out_rd,
    output logic             out_reg_write,
    output logic             out_mem_write,
    output logic             out_mem_read,
    output logic             out_jump,
    output logic             out_branch,
    output logic             out_alu_src,
    output logic [1:0]       out_result_src,
    output logic [2:0]       out_alu_ctrl,
    output logic [31:0]      bubble_cnt
);

    // Reset and flush share one branch so a bubble is bit-identical to the reset state.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_pc_plus4   <= '0;
            out_rd1        <= '0;
            out_rd2        <= '0;
            out_imm        <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_jump       <= 1'b0;
            out_branch     <= 1'b0;
            out_alu_src    <= 1'b0;
            out_result_src <= 2'b00;
            out_alu_ctrl   <= 3'b000;
        end else if (!stall) begin
            out_pc       <= in_pc;
            out_pc_plus4 <= in_pc_plus4;
            out_rd1      <= in_rd1;
            out_rd2      <= in_rd2;
            out_imm      <= in_imm;
            out_rs1      <= in_rs1;
            out_rs2      <= in_rs2;
            out_alu_src  <= in_alu_src;
            // An invalid slot keeps its datapath but can never write state.
            if (in_valid) begin
                out_valid      <= 1'b1;
                out_rd         <= in_rd;
                out_reg_write  <= in_reg_write;
                out_mem_write  <= in_mem_write;
                out_mem_read   <= in_mem_read;
                out_jump       <= in_jump;
                out_branch     <= in_branch;
                out_result_src <= in_result_src;
                out_alu_ctrl   <= in_alu_ctrl;
            end else begin
                out_valid      <= 1'b0;
                out_rd         <= '0;
                out_reg_write  <= 1'b0;
                out_mem_write  <= 1'b0;
                out_mem_read   <= 1'b0;
                out_jump       <= 1'b0;
                out_branch     <= 1'b0;
                out_result_src <= 2'b00;
                out_alu_ctrl   <= 3'b000;
            end
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] cnt_q;

    // Counts flush edges only; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (flush && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bubble_cnt = cnt_q;
`else
    assign bubble_cnt = 32'd0;
`endif

endmodule
